// File: rtl/uart_apu_loader_pkg.sv
// rtl/uart_apu_loader_pkg.sv - shared types, constants and helpers for the UART APU loader
// Contents:
//   rx_state_t  : receiver FSM states (PARITY is only entered when UART_PARITY_EN is defined)
//   SLOT_COMMIT : nibble slot whose write also commits the staging word
//   CMD_SEL_BIT : byte bit that marks a channel-select command
//   clk_div()   : clocks per UART bit
package uart_apu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic [2:0] SLOT_COMMIT = 3'd7;
    localparam int         CMD_SEL_BIT = 7;

    function automatic int clk_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_apu_loader_if.sv
// rtl/uart_apu_loader_if.sv - output bundle of the UART APU loader
// Signals:
//   ch_data    : NUM_CH committed 32-bit register words, channel c at [32c+31:32c]
//   ch_update  : one-cycle commit strobe per channel
//   active_ch  : currently selected channel
//   byte_valid : one-cycle strobe for an accepted byte
//   byte_data  : last accepted byte
//   frame_err  : one-cycle strobe for a dropped byte
// Modports: master (loader drives), slave (APU side reads).
interface uart_apu_loader_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH*32-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_update;
    logic [2:0]           active_ch;
    logic                 byte_valid;
    logic [7:0]           byte_data;
    logic                 frame_err;

    modport master (
        output ch_data, ch_update, active_ch, byte_valid, byte_data, frame_err
    );

    modport slave (
        input ch_data, ch_update, active_ch, byte_valid, byte_data, frame_err
    );
endinterface

// File: rtl/uart_apu_loader_rx.sv
// rtl/uart_apu_loader_rx.sv - UART receiver: 2-FF synchroniser plus framing FSM
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   rx_i         : raw serial input, idle high
//   byte_valid_o : one-cycle strobe, byte_data_o holds the accepted byte
//   byte_data_o  : last accepted byte
//   frame_err_o  : one-cycle strobe, stop bit low (or parity mismatch) and byte dropped
// Build option: UART_PARITY_EN selects 8E1 framing; undefined gives 8N1.
module uart_rx
    import uart_apu_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 9_600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);
    localparam int DIV = clk_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

    logic            rx_meta_q, rx_sync_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic [7:0]      data_q, data_d;
    logic            ferr_q, ferr_d;
`ifdef UART_PARITY_EN
    logic            par_err_q, par_err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchroniser resets to the idle level so reset release never looks like a start bit.
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            ferr_q    <= 1'b0;
`ifdef UART_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            ferr_q    <= ferr_d;
`ifdef UART_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        data_d  = data_q;
        ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Half a bit in: a line back high means a glitch, not a start bit.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d     = '0;
                    // Even parity: data plus parity bit must hold an even number of ones.
                    par_err_d = ^{shift_q, rx_sync_q};
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
`ifdef UART_PARITY_EN
                    if (rx_sync_q && !par_err_q) begin
`else
                    if (rx_sync_q) begin
`endif
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        // A low stop bit may be a break; hold off until the line idles.
                        state_d = rx_sync_q ? IDLE : BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                if (rx_sync_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = data_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_apu_loader.sv
// rtl/uart_apu_loader.sv - UART-fed nibble loader for a bank of APU channel register words
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   rx         : UART serial input, idle high
//   bus        : uart_apu_loader_if.master (ch_data, ch_update, active_ch, byte_valid, byte_data, frame_err)
// Build option: UART_PARITY_EN (8E1 framing in the receiver; decode unaffected).
module uart_apu_loader
    import uart_apu_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 9_600,
    parameter int NUM_CH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    uart_apu_loader_if.master  bus
);
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;

    logic [31:0]          staging_q, staging_d;
    logic [2:0]           active_q, active_d;
    logic [NUM_CH*32-1:0] ch_data_q, ch_data_d;
    logic [NUM_CH-1:0]    ch_update_q, ch_update_d;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx),
        .byte_valid_o (rx_valid),
        .byte_data_o  (rx_data),
        .frame_err_o  (rx_ferr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging_q   <= '0;
            active_q    <= '0;
            ch_data_q   <= '0;
            ch_update_q <= '0;
        end else begin
            staging_q   <= staging_d;
            active_q    <= active_d;
            ch_data_q   <= ch_data_d;
            ch_update_q <= ch_update_d;
        end
    end

    always_comb begin
        staging_d   = staging_q;
        active_d    = active_q;
        ch_data_d   = ch_data_q;
        ch_update_d = '0;
        if (rx_valid) begin
            if (rx_data[CMD_SEL_BIT]) begin
                staging_d = '0;
                if (32'(rx_data[2:0]) < NUM_CH) begin
                    active_d = rx_data[2:0];
                end
            end else begin
                staging_d[{rx_data[6:4], 2'b00} +: 4] = rx_data[3:0];
                // The commit word already carries the slot-7 nibble of this byte.
                if (rx_data[6:4] == SLOT_COMMIT) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (active_q == 3'(c)) begin
                            ch_data_d[c*32 +: 32] = staging_d;
                            ch_update_d[c]        = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.ch_data    = ch_data_q;
    assign bus.ch_update  = ch_update_q;
    assign bus.active_ch  = active_q;
    assign bus.byte_valid = rx_valid;
    assign bus.byte_data  = rx_data;
    assign bus.frame_err  = rx_ferr;

endmodule

// File: tb/tb_uart_apu_loader.sv
// tb/tb_uart_apu_loader.sv - directed, table-driven bench for uart_apu_loader
module tb_uart_apu_loader;
    localparam int BAUD   = 9_600;
    localparam int CLK_HZ = BAUD * 16;
    localparam int NUM_CH = 4;
    localparam int DIV    = 16;

    typedef struct {
        logic [7:0]  b;
        logic        stop;
        logic [3:0]  upd;
        logic [2:0]  act;
        int          chk;
        logic [31:0] word;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int fcnt = 0;
    int updn = 0;
    logic [3:0] upd_acc = '0;
    vec_t tv[$];

    uart_apu_loader_if #(.NUM_CH(NUM_CH)) bus ();

    uart_apu_loader #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.byte_valid) vcnt++;
        if (bus.frame_err) fcnt++;
        if (bus.ch_update != '0) updn++;
        upd_acc = upd_acc | bus.ch_update;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_PARITY_EN
        send_bit((^b) ^ par_flip);
`else
        if (par_flip) rx = 1'b1;
`endif
        send_bit(stop_v);
        rx = 1'b1;
    endtask

    task automatic add(input logic [7:0] b, input logic stop, input logic [3:0] upd,
                       input logic [2:0] act, input int chk, input logic [31:0] word);
        vec_t v;
        v.b = b; v.stop = stop; v.upd = upd; v.act = act; v.chk = chk; v.word = word;
        tv.push_back(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ch_data0"}, bus.ch_data[31:0], 32'h0);
        check({tag, "_ch_data1"}, bus.ch_data[63:32], 32'h0);
        check({tag, "_ch_data2"}, bus.ch_data[95:64], 32'h0);
        check({tag, "_ch_data3"}, bus.ch_data[127:96], 32'h0);
        check({tag, "_ch_update"}, 32'(bus.ch_update), 32'h0);
        check({tag, "_active_ch"}, 32'(bus.active_ch), 32'h0);
        check({tag, "_byte_valid"}, 32'(bus.byte_valid), 32'h0);
        check({tag, "_byte_data"}, 32'(bus.byte_data), 32'h0);
        check({tag, "_frame_err"}, 32'(bus.frame_err), 32'h0);
    endtask

    task automatic run_byte(input string tag, input logic [7:0] b, input logic stop, input logic par_flip,
                            input logic exp_ok, input logic [3:0] exp_upd, input logic [2:0] exp_act,
                            input int chk, input logic [31:0] exp_word);
        int v0, f0, u0;
        v0 = vcnt; f0 = fcnt; u0 = updn;
        upd_acc = '0;
        send_frame(b, stop, par_flip);
        check({tag, "_valid_n"}, 32'(vcnt - v0), 32'(exp_ok));
        check({tag, "_ferr_n"}, 32'(fcnt - f0), 32'(!exp_ok));
        check({tag, "_update_mask"}, 32'(upd_acc), 32'(exp_upd));
        check({tag, "_update_cycles"}, 32'(updn - u0), 32'(exp_upd != '0));
        check({tag, "_active_ch"}, 32'(bus.active_ch), 32'(exp_act));
        if (exp_ok) check({tag, "_byte_data"}, 32'(bus.byte_data), 32'(b));
        check({tag, "_ch_word"}, bus.ch_data[chk*32 +: 32], exp_word);
        if (!exp_ok) repeat (2 * DIV) @(negedge clk);
    endtask

    initial begin
        int v0, f0;
        // Channel 0 load, bytes arrive back to back
        add(8'h27, 1, 4'b0000, 3'd0, 0, 32'h0);
        add(8'h3A, 1, 4'b0000, 3'd0, 0, 32'h0);
        add(8'h02, 1, 4'b0000, 3'd0, 0, 32'h0);
        add(8'h18, 1, 4'b0000, 3'd0, 0, 32'h0);
        add(8'h4C, 1, 4'b0000, 3'd0, 0, 32'h0);
        add(8'h57, 1, 4'b0000, 3'd0, 0, 32'h0);
        add(8'h69, 1, 4'b0000, 3'd0, 0, 32'h0);
        add(8'h70, 1, 4'b0001, 3'd0, 0, 32'h097CA782);
        // Select channel 1 and load it
        add(8'h81, 1, 4'b0000, 3'd1, 0, 32'h097CA782);
        add(8'h23, 1, 4'b0000, 3'd1, 1, 32'h0);
        add(8'h39, 1, 4'b0000, 3'd1, 1, 32'h0);
        add(8'h0E, 1, 4'b0000, 3'd1, 1, 32'h0);
        add(8'h19, 1, 4'b0000, 3'd1, 1, 32'h0);
        add(8'h4A, 1, 4'b0000, 3'd1, 1, 32'h0);
        add(8'h53, 1, 4'b0000, 3'd1, 1, 32'h0);
        add(8'h6A, 1, 4'b0000, 3'd1, 1, 32'h0);
        add(8'h70, 1, 4'b0010, 3'd1, 1, 32'h0A3A939E);
        // Out-of-range select is ignored; a full reload still lands on channel 1
        add(8'h87, 1, 4'b0000, 3'd1, 0, 32'h097CA782);
        add(8'h05, 1, 4'b0000, 3'd1, 1, 32'h0A3A939E);
        add(8'h14, 1, 4'b0000, 3'd1, 1, 32'h0A3A939E);
        add(8'h23, 1, 4'b0000, 3'd1, 1, 32'h0A3A939E);
        add(8'h32, 1, 4'b0000, 3'd1, 1, 32'h0A3A939E);
        add(8'h41, 1, 4'b0000, 3'd1, 1, 32'h0A3A939E);
        add(8'h50, 1, 4'b0000, 3'd1, 1, 32'h0A3A939E);
        add(8'h6F, 1, 4'b0000, 3'd1, 1, 32'h0A3A939E);
        add(8'h7E, 1, 4'b0010, 3'd1, 1, 32'hEF012345);
        // Bad stop bit on 0x2B: dropped, staging slot 2 keeps 3
        add(8'h2B, 0, 4'b0000, 3'd1, 1, 32'hEF012345);
        add(8'h71, 1, 4'b0010, 3'd1, 1, 32'h1F012345);

        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (DIV) @(negedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            run_byte($sformatf("vec%0d", i), tv[i].b, tv[i].stop, 1'b0, tv[i].stop,
                     tv[i].upd, tv[i].act, tv[i].chk, tv[i].word);
        end
        check("ch0_hold", bus.ch_data[31:0], 32'h097CA782);
        check("ch2_zero", bus.ch_data[95:64], 32'h0);
        check("ch3_zero", bus.ch_data[127:96], 32'h0);

        // Short low glitch on an idle line
        v0 = vcnt; f0 = fcnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        check("glitch_valid_n", 32'(vcnt - v0), 32'd0);
        check("glitch_ferr_n", 32'(fcnt - f0), 32'd0);

        // Reset in the middle of the data bits of 0x69
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (DIV) @(negedge clk);
        run_byte("post_rst_12", 8'h12, 1'b1, 1'b0, 1'b1, 4'b0000, 3'd0, 0, 32'h0);
        run_byte("post_rst_7F", 8'h7F, 1'b1, 1'b0, 1'b1, 4'b0001, 3'd0, 0, 32'hF0000020);
        check("post_rst_ch1", bus.ch_data[63:32], 32'h0);

`ifdef UART_PARITY_EN
        run_byte("bad_parity_27", 8'h27, 1'b1, 1'b1, 1'b0, 4'b0000, 3'd0, 0, 32'hF0000020);
        run_byte("after_parity_75", 8'h75, 1'b1, 1'b0, 1'b1, 4'b0001, 3'd0, 0, 32'h50000020);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
